pc_fetch_unit: RTL and testbench

- Registered program-counter stage for the 5-stage pipeline.
- Holds the current fetch PC and advances it by 4 each cycle.
- Computes PC-relative branch targets: sign-extend the offset, shift left 2, add to the branch's own PC. Also supports register-indirect targets (BR).
- Tolerates fetch stalls by latching a redirect that arrives while stalled and applying it when the stall releases.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_target_calc.sv | 50 +++++
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants and types for the program-counter fetch
//                stage: PC increment, default address/offset widths and the
//                next-PC source select encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Byte distance between consecutive sequential instructions.
    localparam int PC_INC = 4;

    // Default widths for the fetch stage and its target calculator.
    localparam int PC_ADDR_W = 64;
    localparam int PC_COND_W = 19;
    localparam int PC_BR_W   = 26;

    // Source of the value loaded into the PC on the next rising edge.
    typedef enum logic [1:0] {
        SRC_SEQ     = 2'd0,  // pc + 4
        SRC_BRANCH  = 2'd1,  // freshly resolved redirect target
        SRC_PENDING = 2'd2,  // redirect latched during an earlier stall
        SRC_HOLD    = 2'd3   // stalled: pc keeps its value
    } pc_src_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_calc
//  Description : Combinational branch-target generator. Selects the
//                conditional or unconditional word offset, sign-extends it to
//                the address width, converts it to bytes and adds it to the
//                branch's own PC. A register-indirect target overrides the
//                PC-relative path and is passed through unmodified.
//  Ports       : i_uncond_br   - 1 = use i_br_addr, 0 = use i_cond_addr
//                i_br_reg_sel  - 1 = target is i_reg_target
//                i_br_pc       - PC of the branch being resolved
//                i_cond_addr   - signed conditional offset, in words
//                i_br_addr     - signed unconditional offset, in words
//                i_reg_target  - register-indirect target
//                o_tgt         - computed redirect target
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter int COND_W = PC_COND_W,
    parameter int BR_W   = PC_BR_W
) (
    input  logic              i_uncond_br,
    input  logic              i_br_reg_sel,
    input  logic [ADDR_W-1:0] i_br_pc,
    input  logic [COND_W-1:0] i_cond_addr,
    input  logic [BR_W-1:0]   i_br_addr,
    input  logic [ADDR_W-1:0] i_reg_target,
    output logic [ADDR_W-1:0] o_tgt
);

    logic [ADDR_W-1:0] w_cond_sext;
    logic [ADDR_W-1:0] w_br_sext;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_rel_tgt;

    assign w_cond_sext = {{(ADDR_W-COND_W){i_cond_addr[COND_W-1]}}, i_cond_addr};
    assign w_br_sext   = {{(ADDR_W-BR_W){i_br_addr[BR_W-1]}}, i_br_addr};
    assign w_off       = i_uncond_br ? w_br_sext : w_cond_sext;

    // Offsets are in words; the shift converts to bytes. The sum wraps
    // modulo 2^ADDR_W with no overflow indication.
    assign w_rel_tgt   = i_br_pc + (w_off << 2);

    assign o_tgt       = i_br_reg_sel ? i_reg_target : w_rel_tgt;

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Registered program-counter stage. Advances the PC by 4 per
//                cycle, applies branch redirects one cycle after they are
//                presented, and latches a redirect that arrives during a
//                fetch stall so it can be applied once the stall releases.
//  Ports       : clk              - clock, rising-edge active
//                reset            - synchronous active-high reset
//                stall            - hold the PC
//                br_taken         - redirect request
//                uncond_br        - offset select (1 = br_addr)
//                br_reg_sel       - 1 = redirect to reg_target
//                br_pc            - PC of the resolving branch
//                cond_addr        - signed conditional word offset
//                br_addr          - signed unconditional word offset
//                reg_target       - register-indirect target
//                pc               - current fetch PC (registered)
//                pc_plus4         - pc + 4 (combinational)
//                redirect_pending - a latched redirect awaits stall release
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                 ADDR_W   = PC_ADDR_W,
    parameter int                 COND_W   = PC_COND_W,
    parameter int                 BR_W     = PC_BR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic              uncond_br,
    input  logic              br_reg_sel,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [COND_W-1:0] cond_addr,
    input  logic [BR_W-1:0]   br_addr,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect_pending
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pending_valid;
    logic [ADDR_W-1:0] r_pending_target;

    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_pc_plus4;
    pc_src_e           w_pc_src;

    pc_target_calc #(
        .ADDR_W (ADDR_W),
        .COND_W (COND_W),
        .BR_W   (BR_W)
    ) u_target_calc (
        .i_uncond_br  (uncond_br),
        .i_br_reg_sel (br_reg_sel),
        .i_br_pc      (br_pc),
        .i_cond_addr  (cond_addr),
        .i_br_addr    (br_addr),
        .i_reg_target (reg_target),
        .o_tgt        (w_tgt)
    );

    assign w_pc_plus4 = r_pc + ADDR_W'(PC_INC);

    // Next-PC priority: stall holds, then a fresh redirect, then a redirect
    // latched during an earlier stall, then sequential fetch.
    always_comb begin
        w_pc_src = SRC_SEQ;
        if (stall) begin
            w_pc_src = SRC_HOLD;
        end else if (br_taken) begin
            w_pc_src = SRC_BRANCH;
        end else if (r_pending_valid) begin
            w_pc_src = SRC_PENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_pending_valid  <= 1'b0;
            r_pending_target <= '0;
        end else begin
            case (w_pc_src)
                SRC_BRANCH:  r_pc <= w_tgt;
                SRC_PENDING: r_pc <= r_pending_target;
                SRC_HOLD:    r_pc <= r_pc;
                default:     r_pc <= w_pc_plus4;
            endcase

            // While stalled the newest redirect overwrites any older one.
            // Any unstalled cycle either consumes the pending redirect or
            // supersedes it with a fresh one, so it is always cleared.
            if (stall) begin
                if (br_taken) begin
                    r_pending_valid  <= 1'b1;
                    r_pending_target <= w_tgt;
                end
            end else begin
                r_pending_valid <= 1'b0;
            end
        end
    end

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign redirect_pending = r_pending_valid;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Self-checking bench for pc_fetch_unit. Directed scenarios
//                against hand-derived constants, followed by randomized
//                traffic checked against a behavioural model of the PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int ADDR_W = 64;
    localparam int COND_W = 19;
    localparam int BR_W   = 26;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              br_taken;
    logic              uncond_br;
    logic              br_reg_sel;
    logic [ADDR_W-1:0] br_pc;
    logic [COND_W-1:0] cond_addr;
    logic [BR_W-1:0]   br_addr;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect_pending;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [ADDR_W-1:0] m_pc;
    logic              m_pend;
    logic [ADDR_W-1:0] m_pend_tgt;

    pc_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .COND_W   (COND_W),
        .BR_W     (BR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .br_taken         (br_taken),
        .uncond_br        (uncond_br),
        .br_reg_sel       (br_reg_sel),
        .br_pc            (br_pc),
        .cond_addr        (cond_addr),
        .br_addr          (br_addr),
        .reg_target       (reg_target),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    // Target from the architectural rule: signed word offset times 4 added
    // to the branch PC, or the register value when register-indirect.
    function automatic logic [ADDR_W-1:0] model_target();
        longint off;
        if (br_reg_sel) return reg_target;
        if (uncond_br) off = longint'($signed(br_addr));
        else           off = longint'($signed(cond_addr));
        return br_pc + ADDR_W'(off * 4);
    endfunction

    // One clock: evaluate the model from the inputs present at the edge,
    // then let outputs settle 1 time unit after the edge.
    task automatic cycle();
        logic [ADDR_W-1:0] t;
        t = model_target();
        if (reset) begin
            m_pc = RESET_PC; m_pend = 1'b0; m_pend_tgt = '0;
        end else if (stall) begin
            if (br_taken) begin m_pend = 1'b1; m_pend_tgt = t; end
        end else if (br_taken) begin
            m_pc = t; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_pend_tgt; m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; br_taken = 0; uncond_br = 0; br_reg_sel = 0;
        br_pc = '0; cond_addr = '0; br_addr = '0; reg_target = '0;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] exp;
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        n_cmp++;
        if (pc !== 64'd0 || redirect_pending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: pc=%h pend=%b required pc=0 pend=0", pc, redirect_pending);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            exp = 64'(i * 4);
            n_cmp++;
            if (pc !== exp || redirect_pending !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle%0d: pc=%h pend=%b required pc=%h pend=0", i, pc, redirect_pending, exp);
            end
        end
        n_cmp++;
        if (pc_plus4 !== 64'd16) begin
            n_err++;
            $display("FAIL pc_plus4: got %h required %h", pc_plus4, 64'd16);
        end
    endtask

    task automatic test_cond_branch();
        br_pc = 64'h10; cond_addr = 19'd30; uncond_br = 0; br_taken = 1;
        cycle();
        br_taken = 0;
        n_cmp++;
        if (pc !== 64'h88) begin
            n_err++;
            $display("FAIL cond_branch: pc=%h required %h", pc, 64'h88);
        end
        cycle();
        n_cmp++;
        if (pc !== 64'h8C) begin
            n_err++;
            $display("FAIL cond_branch_seq: pc=%h required %h", pc, 64'h8C);
        end
    endtask

    task automatic test_uncond_neg();
        br_pc = 64'h100; br_addr = 26'h3FFFFFE; uncond_br = 1; br_taken = 1;
        cycle();
        br_taken = 0; uncond_br = 0;
        n_cmp++;
        if (pc !== 64'hF8) begin
            n_err++;
            $display("FAIL uncond_neg: pc=%h required %h", pc, 64'hF8);
        end
        // all-ones conditional offset is -1 word
        br_pc = 64'h200; cond_addr = '1; br_taken = 1;
        cycle();
        br_taken = 0;
        n_cmp++;
        if (pc !== 64'h1FC) begin
            n_err++;
            $display("FAIL cond_minus1: pc=%h required %h", pc, 64'h1FC);
        end
    endtask

    task automatic test_stall_redirect();
        // position pc at 0x20 via a register redirect
        br_reg_sel = 1; reg_target = 64'h20; br_taken = 1;
        cycle();
        br_reg_sel = 0;
        stall = 1; br_pc = 64'h40; cond_addr = 19'd1; uncond_br = 0; br_taken = 1;
        cycle();
        br_taken = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pc !== 64'h20 || redirect_pending !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold%0d: pc=%h pend=%b required pc=20 pend=1", i, pc, redirect_pending);
            end
            if (i < 2) cycle();
        end
        stall = 0;
        cycle();
        n_cmp++;
        if (pc !== 64'h44 || redirect_pending !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: pc=%h pend=%b required pc=44 pend=0", pc, redirect_pending);
        end
        cycle();
        n_cmp++;
        if (pc !== 64'h48) begin
            n_err++;
            $display("FAIL stall_after: pc=%h required %h", pc, 64'h48);
        end
    endtask

    task automatic test_reg_wrap();
        br_reg_sel = 1; reg_target = 64'hFFFF_FFFF_FFFF_FFFC; br_taken = 1;
        cycle();
        br_taken = 0; br_reg_sel = 0;
        n_cmp++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++;
            $display("FAIL reg_target: pc=%h required %h", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        cycle();
        n_cmp++;
        if (pc !== 64'h0) begin
            n_err++;
            $display("FAIL wrap0: pc=%h required 0", pc);
        end
        cycle();
        n_cmp++;
        if (pc !== 64'h4) begin
            n_err++;
            $display("FAIL wrap4: pc=%h required 4", pc);
        end
    endtask

    task automatic test_reset_pending();
        stall = 1; br_reg_sel = 1; reg_target = 64'h1234_5670; br_taken = 1;
        cycle();
        br_taken = 0; br_reg_sel = 0;
        n_cmp++;
        if (redirect_pending !== 1'b1) begin
            n_err++;
            $display("FAIL pend_set: pend=%b required 1", redirect_pending);
        end
        reset = 1;
        cycle();
        reset = 0;
        n_cmp++;
        if (pc !== RESET_PC || redirect_pending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_pend: pc=%h pend=%b required pc=%h pend=0", pc, redirect_pending, RESET_PC);
        end
        cycle();
        stall = 0;
        cycle();
        n_cmp++;
        if (pc !== RESET_PC + 64'd4) begin
            n_err++;
            $display("FAIL reset_discard: pc=%h required %h", pc, RESET_PC + 64'd4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 99) < 3);
            stall      = ($urandom_range(0, 99) < 30);
            br_taken   = ($urandom_range(0, 99) < 25);
            uncond_br  = $urandom_range(0, 1) == 1;
            br_reg_sel = ($urandom_range(0, 99) < 20);
            br_pc      = {$urandom, $urandom};
            cond_addr  = COND_W'($urandom);
            br_addr    = BR_W'($urandom);
            reg_target = {$urandom, $urandom};
            cycle();
            n_cmp++;
            if (pc !== m_pc || redirect_pending !== m_pend || pc_plus4 !== m_pc + 64'd4) begin
                n_err++;
                $display("FAIL random%0d: pc=%h pend=%b p4=%h required pc=%h pend=%b p4=%h",
                         i, pc, redirect_pending, pc_plus4, m_pc, m_pend, m_pc + 64'd4);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = '0; m_pend = 1'b0; m_pend_tgt = '0;
        idle_inputs();
        test_reset();
        test_cond_branch();
        test_uncond_neg();
        test_stall_redirect();
        test_reg_wrap();
        test_reset_pending();
        // resynchronise the model with a reset before random traffic
        reset = 1;
        cycle();
        reset = 0;
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
